insn_converter: RTL and testbench

INSN_CONVERTER -- requirements
Module: insn_converter

---
 rtl/insn_converter_pkg.sv | 76 +++++++
 rtl/insn_converter_expand.sv | 74 +++++++
 rtl/insn_converter.sv | 86 ++++++++
 tb/tb_insn_converter.sv | 122 ++++++++++++
 4 files changed

// File: rtl/insn_converter_pkg.sv
// Shared opcode/XO constants, state encoding and opcode-mapping helpers for insn_converter.
// Build option: MULTIPLE_EN enables lmw/stmw expansion.
package insn_converter_pkg;

    localparam int unsigned IDX_W = 5;

    localparam logic [5:0] OP_ADDI = 6'd14;
    localparam logic [5:0] OP_X31  = 6'd31;
    localparam logic [5:0] OP_LWZ  = 6'd32;
    localparam logic [5:0] OP_LWZU = 6'd33;
    localparam logic [5:0] OP_LBZ  = 6'd34;
    localparam logic [5:0] OP_LBZU = 6'd35;
    localparam logic [5:0] OP_STW  = 6'd36;
    localparam logic [5:0] OP_STWU = 6'd37;
    localparam logic [5:0] OP_STB  = 6'd38;
    localparam logic [5:0] OP_STBU = 6'd39;
    localparam logic [5:0] OP_LHZ  = 6'd40;
    localparam logic [5:0] OP_LHZU = 6'd41;
    localparam logic [5:0] OP_LHA  = 6'd42;
    localparam logic [5:0] OP_LHAU = 6'd43;
    localparam logic [5:0] OP_STH  = 6'd44;
    localparam logic [5:0] OP_STHU = 6'd45;
    localparam logic [5:0] OP_LMW  = 6'd46;
    localparam logic [5:0] OP_STMW = 6'd47;

    localparam logic [9:0] XO_LWZX  = 10'd23;
    localparam logic [9:0] XO_LWZUX = 10'd55;
    localparam logic [9:0] XO_LBZX  = 10'd87;
    localparam logic [9:0] XO_LBZUX = 10'd119;
    localparam logic [9:0] XO_STWX  = 10'd151;
    localparam logic [9:0] XO_STWUX = 10'd183;
    localparam logic [9:0] XO_STBX  = 10'd215;
    localparam logic [9:0] XO_STBUX = 10'd247;
    localparam logic [9:0] XO_LHZX  = 10'd279;
    localparam logic [9:0] XO_LHZUX = 10'd311;
    localparam logic [9:0] XO_LHAX  = 10'd343;
    localparam logic [9:0] XO_LHAUX = 10'd375;
    localparam logic [9:0] XO_STHX  = 10'd407;
    localparam logic [9:0] XO_STHUX = 10'd439;

    localparam logic [31:0] ADD_BASE = 32'h7C00_0214;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEQ  = 1'b1
    } state_t;

    // D-form update opcode -> plain opcode; returns 6'd0 when op is not an update form
    function automatic logic [5:0] d_plain_op(input logic [5:0] op);
        case (op)
            OP_LWZU: d_plain_op = OP_LWZ;
            OP_LBZU: d_plain_op = OP_LBZ;
            OP_LHZU: d_plain_op = OP_LHZ;
            OP_LHAU: d_plain_op = OP_LHA;
            OP_STWU: d_plain_op = OP_STW;
            OP_STBU: d_plain_op = OP_STB;
            OP_STHU: d_plain_op = OP_STH;
            default: d_plain_op = 6'd0;
        endcase
    endfunction

    // X-form update XO -> indexed XO; returns 10'd0 when xo is not an update form
    function automatic logic [9:0] x_plain_xo(input logic [9:0] xo);
        case (xo)
            XO_LWZUX: x_plain_xo = XO_LWZX;
            XO_LBZUX: x_plain_xo = XO_LBZX;
            XO_LHZUX: x_plain_xo = XO_LHZX;
            XO_LHAUX: x_plain_xo = XO_LHAX;
            XO_STWUX: x_plain_xo = XO_STWX;
            XO_STBUX: x_plain_xo = XO_STBX;
            XO_STHUX: x_plain_xo = XO_STHX;
            default:  x_plain_xo = 10'd0;
        endcase
    endfunction

endpackage

// File: rtl/insn_converter_expand.sv
// Combinational micro-op generator: builds micro-op[idx] of an instruction and flags the last one.
// Build option: MULTIPLE_EN enables lmw/stmw expansion.
module insn_expand
    import insn_converter_pkg::*;
(
    input  logic [31:0]      insn,
    input  logic [IDX_W-1:0] idx,
    output logic [31:0]      uop,
    output logic             conv,
    output logic             last
);

    logic [5:0] op_s;
    logic [4:0] rd_s;
    logic [4:0] ra_s;
    logic [4:0] rb_s;
    logic [9:0] xo_s;
    logic [5:0] d_op_s;
    logic [9:0] x_xo_s;
    logic [4:0] m_reg_s;
    logic [15:0] m_disp_s;

    assign op_s     = insn[31:26];
    assign rd_s     = insn[25:21];
    assign ra_s     = insn[20:16];
    assign rb_s     = insn[15:11];
    assign xo_s     = insn[10:1];
    assign d_op_s   = d_plain_op(op_s);
    assign x_xo_s   = x_plain_xo(xo_s);
    assign m_reg_s  = rd_s + idx;
    assign m_disp_s = insn[15:0] + {9'd0, idx, 2'b00};

    // Select micro-op by instruction class; unrecognised encodings pass through as a single op
    always_comb begin
        uop  = insn;
        conv = 1'b0;
        last = 1'b1;
        if (d_op_s != 6'd0) begin
            conv = 1'b1;
            if (idx == {IDX_W{1'b0}}) begin
                uop  = {d_op_s, insn[25:0]};
                last = 1'b0;
            end else begin
                uop  = {OP_ADDI, ra_s, ra_s, insn[15:0]};
                last = 1'b1;
            end
        end else if ((op_s == OP_X31) && (x_xo_s != 10'd0)) begin
            conv = 1'b1;
            if (idx == {IDX_W{1'b0}}) begin
                uop  = {insn[31:11], x_xo_s, insn[0]};
                last = 1'b0;
            end else begin
                uop  = ADD_BASE | {6'd0, ra_s, 21'd0} | {11'd0, ra_s, 16'd0} | {16'd0, rb_s, 11'd0};
                last = 1'b1;
            end
`ifdef MULTIPLE_EN
        end else if ((op_s == OP_LMW) || (op_s == OP_STMW)) begin
            conv = 1'b1;
            uop  = {(op_s == OP_LMW) ? OP_LWZ : OP_STW, m_reg_s, ra_s, m_disp_s};
            last = (m_reg_s == 5'd31);
`endif
        end else begin
            uop  = insn;
            conv = 1'b0;
            last = 1'b1;
        end
    end

`ifndef MULTIPLE_EN
    logic unused_s;
    assign unused_s = ^{m_reg_s, m_disp_s};
`endif

endmodule

// File: rtl/insn_converter.sv
// Splits PowerPC update-form (and, with MULTIPLE_EN, lmw/stmw) loads/stores into plain micro-ops.
// Build option: MULTIPLE_EN enables lmw/stmw expansion.
module insn_converter
    import insn_converter_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] PC,
    input  logic [31:0] din,
    output logic        ext_stall,
    output logic [31:0] dout
);

    state_t           state_r;
    state_t           state_nxt_s;
    logic [IDX_W-1:0] idx_r;
    logic [IDX_W-1:0] idx_nxt_s;
    logic [31:0]      insn_r;
    logic [31:0]      insn_nxt_s;
    logic [31:0]      pc_r;
    logic [31:0]      pc_nxt_s;

    logic             run_seq_s;
    logic [31:0]      exp_insn_s;
    logic [IDX_W-1:0] exp_idx_s;
    logic [31:0]      uop_s;
    logic             conv_s;
    logic             last_s;

    // A PC change while sequencing is a redirect: drop the sequence and decode din afresh
    assign run_seq_s  = (state_r == ST_SEQ) && (PC == pc_r);
    assign exp_insn_s = run_seq_s ? insn_r : din;
    assign exp_idx_s  = run_seq_s ? idx_r : {IDX_W{1'b0}};

    insn_expand u_expand (
        .insn (exp_insn_s),
        .idx  (exp_idx_s),
        .uop  (uop_s),
        .conv (conv_s),
        .last (last_s)
    );

    assign dout      = uop_s;
    assign ext_stall = rst_n & conv_s & ~last_s;

    // Next-state and latch-update logic
    always_comb begin
        state_nxt_s = state_r;
        idx_nxt_s   = idx_r;
        insn_nxt_s  = insn_r;
        pc_nxt_s    = pc_r;
        if (run_seq_s) begin
            if (last_s) begin
                state_nxt_s = ST_IDLE;
                idx_nxt_s   = {IDX_W{1'b0}};
            end else begin
                state_nxt_s = ST_SEQ;
                idx_nxt_s   = idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
            end
        end else if (conv_s && !last_s) begin
            state_nxt_s = ST_SEQ;
            idx_nxt_s   = {{(IDX_W-1){1'b0}}, 1'b1};
            insn_nxt_s  = din;
            pc_nxt_s    = PC;
        end else begin
            state_nxt_s = ST_IDLE;
            idx_nxt_s   = {IDX_W{1'b0}};
        end
    end

    // State and latched-instruction registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            idx_r   <= {IDX_W{1'b0}};
            insn_r  <= 32'd0;
            pc_r    <= 32'd0;
        end else begin
            state_r <= state_nxt_s;
            idx_r   <= idx_nxt_s;
            insn_r  <= insn_nxt_s;
            pc_r    <= pc_nxt_s;
        end
    end

endmodule

// File: tb/tb_insn_converter.sv
// Directed self-checking bench for insn_converter; expectations adapt to MULTIPLE_EN.
module tb_insn_converter;

    logic        clk;
    logic        rst_n;
    logic [31:0] PC;
    logic [31:0] din;
    logic        ext_stall;
    logic [31:0] dout;

    int n_assert = 0;
    int n_fail   = 0;

    insn_converter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .PC        (PC),
        .din       (din),
        .ext_stall (ext_stall),
        .dout      (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] exp_dout, input logic exp_stall);
        n_assert++;
        assert (dout === exp_dout) else begin
            n_fail++;
            $error("FAIL %s dout: got %h expected %h", tag, dout, exp_dout);
        end
        n_assert++;
        assert (ext_stall === exp_stall) else begin
            n_fail++;
            $error("FAIL %s stall: got %b expected %b", tag, ext_stall, exp_stall);
        end
    endtask

    // One fetch cycle: drive after a rising edge, check at the falling edge
    task automatic cyc(input string tag, input logic [31:0] d, input logic [31:0] pc,
                       input logic [31:0] exp_dout, input logic exp_stall);
        din = d;
        PC  = pc;
        @(negedge clk);
        check(tag, exp_dout, exp_stall);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        din   = 32'h0000_0000;
        PC    = 32'h0000_0000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset", 32'h0000_0000, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        cyc("stwu0",  32'h9421_ffe0, 32'h0000_0100, 32'h9021_ffe0, 1'b1);
        cyc("stwu1",  32'h9421_ffe0, 32'h0000_0100, 32'h3821_ffe0, 1'b0);
        cyc("lwzu0",  32'h87fe_0004, 32'h0000_0104, 32'h83fe_0004, 1'b1);
        cyc("lwzu1",  32'h87fe_0004, 32'h0000_0104, 32'h3bde_0004, 1'b0);
        cyc("lwzux0", 32'h7c1f_006e, 32'h0000_0108, 32'h7c1f_002e, 1'b1);
        cyc("lwzux1", 32'h7c1f_006e, 32'h0000_0108, 32'h7fff_0214, 1'b0);
        cyc("stbux0", 32'h7ca3_21ef, 32'h0000_010c, 32'h7ca3_21af, 1'b1);
        cyc("stbux1", 32'h7ca3_21ef, 32'h0000_010c, 32'h7c63_2214, 1'b0);
        cyc("mfspr",  32'h7c08_02a6, 32'h0000_0110, 32'h7c08_02a6, 1'b0);
        cyc("lwzx",   32'h7c1f_002e, 32'h0000_0114, 32'h7c1f_002e, 1'b0);

        // Redirect mid-sequence: the new din is decoded from scratch
        cyc("redir0", 32'h9421_ffe0, 32'h0000_0200, 32'h9021_ffe0, 1'b1);
        cyc("redir1", 32'h7c08_02a6, 32'h0000_0300, 32'h7c08_02a6, 1'b0);
        cyc("redir2", 32'h87fe_0004, 32'h0000_0304, 32'h83fe_0004, 1'b1);
        cyc("redir3", 32'h87fe_0004, 32'h0000_0304, 32'h3bde_0004, 1'b0);

`ifdef MULTIPLE_EN
        cyc("lmw0",   32'hbbc1_0018, 32'h0000_0400, 32'h83c1_0018, 1'b1);
        cyc("lmw1",   32'hbbc1_0018, 32'h0000_0400, 32'h83e1_001c, 1'b0);
        cyc("lmw31",  32'hbbe1_0008, 32'h0000_0404, 32'h83e1_0008, 1'b0);
        cyc("post31", 32'h7c08_02a6, 32'h0000_0408, 32'h7c08_02a6, 1'b0);
        cyc("wrap0",  32'hbbc1_fffc, 32'h0000_040c, 32'h83c1_fffc, 1'b1);
        cyc("wrap1",  32'hbbc1_fffc, 32'h0000_040c, 32'h83e1_0000, 1'b0);
        cyc("stmw0",  32'hbf01_0010, 32'h0000_0500, 32'h9301_0010, 1'b1);
        cyc("stmw1",  32'hbf01_0010, 32'h0000_0500, 32'h9321_0014, 1'b1);
        cyc("stmw2",  32'hbf01_0010, 32'h0000_0500, 32'h9341_0018, 1'b1);
        @(negedge clk);
        check("stmw3", 32'h9361_001c, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        check("stmw_rst", 32'h9301_0010, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        cyc("stmw_r0", 32'hbf01_0010, 32'h0000_0500, 32'h9301_0010, 1'b1);
        cyc("stmw_r1", 32'hbf01_0010, 32'h0000_0500, 32'h9321_0014, 1'b1);
        cyc("stmw_ab", 32'h7c08_02a6, 32'h0000_0600, 32'h7c08_02a6, 1'b0);
`else
        cyc("lmw",    32'hbbc1_0018, 32'h0000_0400, 32'hbbc1_0018, 1'b0);
        cyc("lmw31",  32'hbbe1_0008, 32'h0000_0404, 32'hbbe1_0008, 1'b0);
        cyc("stmw",   32'hbf01_0010, 32'h0000_0500, 32'hbf01_0010, 1'b0);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("stmw_rst", 32'hbf01_0010, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        cyc("stmw_r0", 32'hbf01_0010, 32'h0000_0500, 32'hbf01_0010, 1'b0);
`endif

        cyc("final_stwu0", 32'h9421_ffe0, 32'h0000_0700, 32'h9021_ffe0, 1'b1);
        cyc("final_stwu1", 32'h9421_ffe0, 32'h0000_0700, 32'h3821_ffe0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
